// File: rtl/rx_fifo_pkg.sv
// Shared constants, address-width helper and status-flag layout for the receive FIFO.
package rx_fifo_pkg;

    localparam int RX_FIFO_DATA_W_DEF = 8;
    localparam int RX_FIFO_DEPTH_DEF  = 32;

    function automatic int rx_fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bit order matches the status register layout, MSB first.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } rx_fifo_flags_t;

endpackage

// File: rtl/rx_fifo_ram.sv
// DEPTH x DATA_W storage, one write port and one read port.
// Read is asynchronous when RX_FIFO_FWFT_EN is defined, registered otherwise.
module rx_fifo_ram
    import rx_fifo_pkg::*;
#(
    parameter int DATA_W = RX_FIFO_DATA_W_DEF,
    parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
    parameter int AW     = rx_fifo_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array is deliberately left out of reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef RX_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst | rd_en_i;
    assign rd_data_o      = mem_q[rd_addr_i];
`else
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/rx_fifo_sync.sv
// Single-clock receive FIFO: pointers, occupancy, threshold flags and sticky errors.
// Define RX_FIFO_FWFT_EN for first-word fall-through reads.
module rx_fifo_sync
    import rx_fifo_pkg::*;
#(
    parameter  int DATA_W    = RX_FIFO_DATA_W_DEF,
    parameter  int DEPTH     = RX_FIFO_DEPTH_DEF,
    parameter  int AFULL_TH  = 28,
    parameter  int AEMPTY_TH = 4,
    localparam int AW        = rx_fifo_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int            CW       = AW + 1;
    localparam logic [AW:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [AW:0]   AFULL_C  = CW'(AFULL_TH);
    localparam logic [AW:0]   AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rd_data;
    rx_fifo_flags_t    flags;

    always_comb begin
        flags.full         = (count_q == DEPTH_C);
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= AFULL_C);
        flags.almost_empty = (count_q <= AEMPTY_C);
        flags.overflow     = overflow_q;
        flags.underflow    = underflow_q;
    end

    // Accept decisions use only registered flags, so no request reaches an output combinationally.
    assign wr_acc = wr_en & ~flags.full  & ~flush;
    assign rd_acc = rd_en & ~flags.empty & ~flush;

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en && flags.full)  overflow_d  = 1'b1;
            if (rd_en && flags.empty) underflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    rx_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

`ifdef RX_FIFO_FWFT_EN
    // Head word is shown whenever present; zero while empty keeps the reset value visible.
    assign rd_data  = flags.empty ? '0 : ram_rd_data;
    assign rd_valid = ~flags.empty;
`else
    logic rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_data  = ram_rd_data;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign overflow     = flags.overflow;
    assign underflow    = flags.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_rx_fifo_sync.sv
// Directed self-checking bench for rx_fifo_sync in the default registered-read mode.
module tb_rx_fifo_sync;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 32;
    localparam int AFULL_TH  = 28;
    localparam int AEMPTY_TH = 4;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [5:0] count;

    int checks   = 0;
    int failures = 0;

    rx_fifo_sync #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    endtask

    task automatic write_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        // {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}
        checks++;
        if ({full, empty, almost_full, almost_empty, overflow, underflow, rd_valid} !== 7'b0101000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0101000",
                     {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            checks++;
            if (count !== 6'(i + 1) || almost_full !== (i + 1 >= 28) || full !== (i + 1 == 32)
                || almost_empty !== (i + 1 <= 4) || empty !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d got count=%0d af=%b f=%b ae=%b e=%b exp count=%0d af=%b f=%b ae=%b e=0",
                         i, count, almost_full, full, almost_empty, empty,
                         i + 1, (i + 1 >= 28), (i + 1 == 32), (i + 1 <= 4));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 6'(31 - i)) begin
                failures++;
                $display("FAIL drain_%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d",
                         i, rd_valid, rd_data, count, 8'(i), 31 - i);
            end
            rd_en = 1'b0;
            tick();
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== 8'(i)) begin
                failures++;
                $display("FAIL drain_gap_%0d got v=%b d=%h exp v=0 d=%h", i, rd_valid, rd_data, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 6'd0) begin
            failures++; $display("FAIL drain_end got e=%b c=%0d exp e=1 c=0", empty, count);
        end
    endtask

    task automatic test_overflow();
        write_words(32, 8'h00);
        wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        checks++;
        if (overflow !== 1'b1 || count !== 6'd32 || full !== 1'b1) begin
            failures++; $display("FAIL ovf_set got o=%b c=%0d f=%b exp o=1 c=32 f=1", overflow, count, full);
        end
        clr_err = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        wr_en = 1'b0;
        tick();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hBB;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 6'd31 || overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h00 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_wr_rd got c=%0d o=%b v=%b d=%h f=%b exp c=31 o=1 v=1 d=00 f=0",
                     count, overflow, rd_valid, rd_data, full);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick();
            checks++;
            if (rd_data !== 8'(i + 1) || rd_valid !== 1'b1) begin
                failures++; $display("FAIL ovf_drain_%0d got d=%h v=%b exp d=%h v=1", i, rd_data, rd_valid, 8'(i + 1));
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_end got e=%b v=%b o=%b exp e=1 v=0 o=0", empty, rd_valid, overflow);
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 6'd0) begin
            failures++; $display("FAIL unf_set got u=%b v=%b c=%0d exp u=1 v=0 c=0", underflow, rd_valid, count);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", underflow); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 6'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_wr_rd got c=%0d u=%b v=%b e=%b exp c=1 u=1 v=0 e=0", count, underflow, rd_valid, empty);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h55 || rd_valid !== 1'b1 || count !== 6'd0) begin
            failures++; $display("FAIL unf_read got d=%h v=%b c=%0d exp d=55 v=1 c=0", rd_data, rd_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        write_words(10, 8'h80);
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h8A + k);
            tick();
            checks++;
            if (count !== 6'd10 || rd_data !== 8'(8'h80 + k) || rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d got c=%0d d=%h v=%b exp c=10 d=%h v=1", k, count, rd_data, rd_valid, 8'(8'h80 + k));
            end
        end
        wr_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (rd_data !== 8'(8'hA8 + k)) begin
                failures++; $display("FAIL b2b_tail_%0d got=%h exp=%h", k, rd_data, 8'(8'hA8 + k));
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || count !== 6'd0) begin
            failures++; $display("FAIL b2b_end got e=%b c=%0d exp e=1 c=0", empty, count);
        end
    endtask

    // Enters with underflow still set from the underflow scenario.
    task automatic test_flush();
        write_words(5, 8'h10);
        rd_en = 1'b1;
        tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h10
            || overflow !== 1'b0 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL flush got c=%0d e=%b v=%b d=%h o=%b u=%b exp c=0 e=1 v=0 d=10 o=0 u=1",
                     count, empty, rd_valid, rd_data, overflow, underflow);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        flush = 1'b1; rd_en = 1'b1;
        tick();
        flush = 1'b0; rd_en = 1'b0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL flush_no_unf got=%b exp=0", underflow); end
        write_words(1, 8'h77);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h77 || rd_valid !== 1'b1 || count !== 6'd0) begin
            failures++; $display("FAIL flush_reuse got d=%h v=%b c=%0d exp d=77 v=1 c=0", rd_data, rd_valid, count);
        end
    endtask

    task automatic test_rst_mid();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        write_words(3, 8'h21);
        rd_en = 1'b1;
        tick();
        checks++;
        if (underflow !== 1'b1 || rd_data !== 8'h21 || count !== 6'd2) begin
            failures++; $display("FAIL pre_rst got u=%b d=%h c=%0d exp u=1 d=21 c=2", underflow, rd_data, count);
        end
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 6'd0 || rd_data !== 8'h00
            || {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid} !== 7'b0101000) begin
            failures++;
            $display("FAIL rst_mid got c=%0d d=%h flags=%b exp c=0 d=00 flags=0101000", count, rd_data,
                     {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid});
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
